// File: rtl/divisor_pkg.sv
// Shared types and key codes for the operand-entry stage in front of the divider.
package divisor_pkg;

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OUT = 2'd2
    } load_state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;

    // Decimal digit keys occupy codes 0x0-0x9.
    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/dec_accum.sv
// Decimal accumulator for one operand: value = value*10 + digit, with a
// digit-count limit and a range limit of 2^N-1. `ok` tells the FSM whether
// the digit currently on `digit` would be accepted.
module dec_accum #(
    parameter int N          = 4,
    parameter int MAX_DIGITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   digit,
    input  logic         load,
    input  logic         clr,
    input  logic         done,
    output logic [N-1:0] value,
    output logic         ok,
    output logic         empty
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_DIGITS);
    localparam logic [N+3:0]  MAX_VAL = {4'b0000, {N{1'b1}}};

    logic [CW-1:0] count;
    logic [N+3:0]  cand;
    logic [N+3:0]  cur_wide;

    // value*10 as (value<<3)+(value<<1); N+4 bits hold (2^N-1)*10+9.
    assign cur_wide = {4'b0000, value};
    assign cand     = (cur_wide << 3) + (cur_wide << 1) + {{N{1'b0}}, digit};
    assign ok       = (count < MAX_CNT) && (cand <= MAX_VAL);
    assign empty    = (count == '0);

    // Operand and digit count: clear wins, then digit load, then count reset on ENTER.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            value <= '0;
            count <= '0;
        end else if (clr) begin
            value <= '0;
            count <= '0;
        end else if (load) begin
            value <= cand[N-1:0];
            count <= count + CW'(1);
        end else if (done) begin
            count <= '0;
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Operand-entry stage: collects dividend A and divisor B from keypad digits,
// then presents the pair under a valid/ready handshake to the divider.
module operand_loader
    import divisor_pkg::*;
#(
    parameter int N          = 4,
    parameter int MAX_DIGITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    input  logic         op_ready,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    output logic         op_valid,
    output logic         div_zero,
    output logic         entry_err,
    output logic         sel_b
);

    load_state_t state, state_next;

    logic a_load, a_clr, a_done, a_ok, a_empty;
    logic b_load, b_clr, b_done, b_ok, b_empty;
    logic err_next, dz_next;
    logic key_digit, key_enter, key_clear, xfer;

    assign key_digit = key_valid && is_digit(key_code);
    assign key_enter = key_valid && (key_code == KEY_ENTER);
    assign key_clear = key_valid && (key_code == KEY_CLEAR);
    assign xfer      = (state == S_OUT) && op_ready;

    assign op_valid  = (state == S_OUT);
    assign sel_b     = (state == S_B);

    dec_accum #(.N(N), .MAX_DIGITS(MAX_DIGITS)) u_acc_a (
        .clk   (clk),
        .rst   (rst),
        .digit (key_code),
        .load  (a_load),
        .clr   (a_clr),
        .done  (a_done),
        .value (A),
        .ok    (a_ok),
        .empty (a_empty)
    );

    dec_accum #(.N(N), .MAX_DIGITS(MAX_DIGITS)) u_acc_b (
        .clk   (clk),
        .rst   (rst),
        .digit (key_code),
        .load  (b_load),
        .clr   (b_clr),
        .done  (b_done),
        .value (B),
        .ok    (b_ok),
        .empty (b_empty)
    );

    // Key decode and next-state: a transfer in S_OUT takes priority over CLEAR.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_next = state;
        a_load     = 1'b0;
        a_clr      = 1'b0;
        a_done     = 1'b0;
        b_load     = 1'b0;
        b_clr      = 1'b0;
        b_done     = 1'b0;
        err_next   = 1'b0;
        dz_next    = div_zero;

        case (state)
            S_A: begin
                if (key_digit) begin
                    if (a_ok) a_load   = 1'b1;
                    else      err_next = 1'b1;
                end else if (key_enter) begin
                    if (a_empty) begin
                        err_next = 1'b1;
                    end else begin
                        a_done     = 1'b1;
                        state_next = S_B;
                    end
                end else if (key_clear) begin
                    a_clr = 1'b1;
                end
            end
            S_B: begin
                if (key_digit) begin
                    if (b_ok) b_load   = 1'b1;
                    else      err_next = 1'b1;
                end else if (key_enter) begin
                    if (b_empty) begin
                        err_next = 1'b1;
                    end else begin
                        b_done     = 1'b1;
                        dz_next    = (B == '0);
                        state_next = S_OUT;
                    end
                end else if (key_clear) begin
                    b_clr = 1'b1;
                end
            end
            S_OUT: begin
                // Digits and ENTER are silently ignored while the pair is held.
                if (xfer || key_clear) begin
                    a_clr      = 1'b1;
                    b_clr      = 1'b1;
                    dz_next    = 1'b0;
                    state_next = S_A;
                end
            end
            default: begin
                a_clr      = 1'b1;
                b_clr      = 1'b1;
                dz_next    = 1'b0;
                state_next = S_A;
            end
        endcase
    end

    // FSM state, divide-by-zero flag and the one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_A;
            div_zero  <= 1'b0;
            entry_err <= 1'b0;
        end else begin
            state     <= state_next;
            div_zero  <= dz_next;
            entry_err <= err_next;
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: directed test-plan sequences plus
// randomized keys, all compared every cycle against a behavioural model.
module tb_operand_loader;

    localparam int N    = 4;
    localparam int MAXD = 2;
    localparam int VMAX = (1 << N) - 1;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic         op_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         op_valid;
    logic         div_zero;
    logic         entry_err;
    logic         sel_b;

    operand_loader #(.N(N), .MAX_DIGITS(MAXD)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .op_ready  (op_ready),
        .A         (A),
        .B         (B),
        .op_valid  (op_valid),
        .div_zero  (div_zero),
        .entry_err (entry_err),
        .sel_b     (sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = entering A, 1 = entering B, 2 = pair presented.
    int m_phase, m_a, m_b, m_cnt, m_dz, m_err, m_xfers;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_a = 0; m_b = 0; m_cnt = 0; m_dz = 0; m_err = 0;
        end else begin
            int code, cur;
            code  = int'(key_code);
            m_err = 0;
            if (m_phase == 2 && op_ready) begin
                m_xfers++;
                m_phase = 0; m_a = 0; m_b = 0; m_cnt = 0; m_dz = 0;
            end else if (key_valid) begin
                if (code <= 9) begin
                    if (m_phase != 2) begin
                        cur = (m_phase == 0) ? m_a : m_b;
                        if (m_cnt < MAXD && cur * 10 + code <= VMAX) begin
                            if (m_phase == 0) m_a = cur * 10 + code;
                            else              m_b = cur * 10 + code;
                            m_cnt++;
                        end else begin
                            m_err = 1;
                        end
                    end
                end else if (code == 10) begin
                    if (m_phase != 2) begin
                        if (m_cnt == 0) m_err = 1;
                        else begin
                            m_cnt = 0;
                            if (m_phase == 1) m_dz = (m_b == 0) ? 1 : 0;
                            m_phase++;
                        end
                    end
                end else if (code == 11) begin
                    if (m_phase == 0) begin m_a = 0; m_cnt = 0; end
                    else if (m_phase == 1) begin m_b = 0; m_cnt = 0; end
                    else begin m_phase = 0; m_a = 0; m_b = 0; m_dz = 0; end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int dut_xfers = 0;

    always @(negedge clk) begin
        if (!rst) begin
            check("cmp_A",        32'(A),         32'(m_a));
            check("cmp_B",        32'(B),         32'(m_b));
            check("cmp_op_valid", 32'(op_valid),  32'(m_phase == 2));
            check("cmp_sel_b",    32'(sel_b),     32'(m_phase == 1));
            check("cmp_entry_err",32'(entry_err), 32'(m_err));
            if (m_phase == 2)
                check("cmp_div_zero", 32'(div_zero), 32'(m_dz));
            if (op_valid && op_ready) dut_xfers++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic key(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_A"},         32'(A),         0);
        check({tag, "_B"},         32'(B),         0);
        check({tag, "_op_valid"},  32'(op_valid),  0);
        check({tag, "_div_zero"},  32'(div_zero),  0);
        check({tag, "_entry_err"}, 32'(entry_err), 0);
        check({tag, "_sel_b"},     32'(sel_b),     0);
    endtask

    initial begin
        int x0;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        op_ready  = 1'b0;
        m_xfers   = 0;
        #2;
        check_all_zero("reset");
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Basic transfer: 12 / 3
        key(4'd1); key(4'd2); key(4'hA); key(4'd3); key(4'hA);
        check("basic_op_valid", 32'(op_valid), 1);
        check("basic_A",        32'(A),        12);
        check("basic_B",        32'(B),        3);
        check("basic_dz",       32'(div_zero), 0);
        check("model_A_12",     32'(m_a),      12);
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_op_valid", 32'(op_valid), 1);
            check("hold_A",        32'(A),        12);
            check("hold_B",        32'(B),        3);
        end
        op_ready = 1'b1;
        @(posedge clk); #1;
        op_ready = 1'b0;
        check("xfer_op_valid", 32'(op_valid), 0);
        check("xfer_A",        32'(A),        0);
        check("xfer_B",        32'(B),        0);
        check("model_xfers_1", 32'(m_xfers),  1);

        // Range and digit limits
        key(4'd1); key(4'd6);
        check("range_err", 32'(entry_err), 1);
        check("range_A",   32'(A),         1);
        @(posedge clk); #1;
        check("err_one_cycle", 32'(entry_err), 0);
        key(4'hB); key(4'd1); key(4'd5);
        check("max_A",        32'(A), 15);
        check("model_A_15",   32'(m_a), 15);
        key(4'd0);
        check("limit_err", 32'(entry_err), 1);
        check("limit_A",   32'(A),         15);

        // Divide by zero, then abort with CLEAR
        key(4'hB); key(4'd7); key(4'hA); key(4'd0); key(4'hA);
        check("dz_op_valid", 32'(op_valid), 1);
        check("dz_A",        32'(A),        7);
        check("dz_B",        32'(B),        0);
        check("dz_flag",     32'(div_zero), 1);
        check("model_dz",    32'(m_dz),     1);
        key(4'd5); key(4'hA);
        check("out_ignore_err", 32'(entry_err), 0);
        check("out_ignore_A",   32'(A),         7);
        key(4'hB);
        check("abort_op_valid", 32'(op_valid), 0);
        check("abort_sel_b",    32'(sel_b),    0);
        check("abort_dz",       32'(div_zero), 0);
        check("abort_A",        32'(A),        0);

        // Empty entry and clear in S_B
        key(4'hA);
        check("empty_err",   32'(entry_err), 1);
        check("empty_sel_b", 32'(sel_b),     0);
        key(4'd9); key(4'hA); key(4'd4); key(4'hB);
        check("clrb_B",     32'(B),     0);
        check("clrb_A",     32'(A),     9);
        check("clrb_sel_b", 32'(sel_b), 1);
        key(4'hA);
        check("emptyb_err", 32'(entry_err), 1);
        key(4'd2); key(4'hA);
        check("pair2_op_valid", 32'(op_valid), 1);

        // CLEAR together with op_ready: transfer counts
        x0 = m_xfers;
        op_ready = 1'b1;
        key(4'hB);
        op_ready = 1'b0;
        check("clrxfer_model", 32'(m_xfers - x0), 1);
        check("clrxfer_op_valid", 32'(op_valid), 0);
        check("clrxfer_A",        32'(A),        0);

        // Async reset in the middle of B entry
        key(4'd3); key(4'hA); key(4'd5);
        check("pre_rst_sel_b", 32'(sel_b), 1);
        #3 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        #2 rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_sel_b", 32'(sel_b), 0);
        key(4'd4);
        check("post_rst_A",     32'(A),     4);
        check("post_rst_sel_b2",32'(sel_b), 0);

        // Randomized keys and handshake
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 10)      key_code = 4'(r);
            else if (r < 14) key_code = 4'hA;
            else if (r < 16) key_code = 4'hB;
            else             key_code = 4'(12 + (r - 16));
            key_valid = ($urandom_range(0, 1) == 1);
            op_ready  = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        op_ready  = 1'b0;
        @(negedge clk);
        check("xfer_count", 32'(dut_xfers), 32'(m_xfers));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
